// File: rtl/i2s_rx.sv
// I2S capture: oversamples BCLK/LRC/data in the system clock and presents each
// left/right word pair with a valid/ready handshake. Optional sticky overrun flag: I2S_RX_OVERRUN_EN.
module i2s_rx #(
  parameter int BPS = 24
) (
  input  logic           in_clk,
  input  logic           in_rst,
  input  logic           in_BCLK,
  input  logic           in_RECLRC,
  input  logic           in_RECDAT,
  input  logic           in_ready,
  output logic [BPS-1:0] out_left,
  output logic [BPS-1:0] out_right,
  output logic           out_valid,
  output logic           out_overrun
);

  localparam int CW = 6;

  typedef enum logic [1:0] {WAIT_SYNC, DELAY, SHIFT, PAD} state_t;

  // Handshake: a pair is transferred on every in_clk edge where out_valid && in_ready;
  // out_left/out_right are stable whenever out_valid is high and in_ready is low.

  logic           bclk_s1_q, bclk_s2_q, bclk_prev_q;
  logic           lrc_s1_q, lrc_s2_q;
  logic           dat_s1_q, dat_s2_q;
  state_t         state_q, state_d;
  logic           channel_q, channel_d;
  logic           lrc_prev_q, lrc_prev_d;
  logic           left_ok_q, left_ok_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BPS-1:0] shift_q, shift_d;
  logic [BPS-1:0] left_hold_q, left_hold_d;
  logic [BPS-1:0] right_hold_q, right_hold_d;
  logic           pair_q, pair_d;
  logic [BPS-1:0] out_left_q, out_left_d;
  logic [BPS-1:0] out_right_q, out_right_d;
  logic           out_valid_q, out_valid_d;
  logic           rise;

  assign rise = bclk_s2_q & ~bclk_prev_q;

  always_comb begin
    state_d      = state_q;
    channel_d    = channel_q;
    lrc_prev_d   = lrc_prev_q;
    left_ok_d    = left_ok_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    pair_d       = 1'b0;
    if (rise) begin
      lrc_prev_d = lrc_s2_q;
      if (lrc_s2_q != lrc_prev_q) begin
        // The transition rise carries the last bit of the previous slot.
        channel_d = lrc_s2_q;
        state_d   = DELAY;
        bit_cnt_d = '0;
        if (state_q == SHIFT) left_ok_d = 1'b0;
      end else begin
        case (state_q)
          DELAY, SHIFT: begin
            shift_d   = {shift_q[BPS-2:0], dat_s2_q};
            bit_cnt_d = bit_cnt_q + CW'(1);
            state_d   = SHIFT;
            if (bit_cnt_q == CW'(BPS - 1)) begin
              state_d = PAD;
              if (!channel_q) begin
                left_hold_d = shift_d;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                right_hold_d = shift_d;
                pair_d       = 1'b1;
                left_ok_d    = 1'b0;
              end
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q & ~in_ready;
    if (pair_q && (!out_valid_q || in_ready)) begin
      out_left_d  = left_hold_q;
      out_right_d = right_hold_q;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      bclk_s1_q    <= 1'b0;
      bclk_s2_q    <= 1'b0;
      bclk_prev_q  <= 1'b0;
      lrc_s1_q     <= 1'b0;
      lrc_s2_q     <= 1'b0;
      dat_s1_q     <= 1'b0;
      dat_s2_q     <= 1'b0;
      state_q      <= WAIT_SYNC;
      channel_q    <= 1'b0;
      lrc_prev_q   <= 1'b0;
      left_ok_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      pair_q       <= 1'b0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      bclk_s1_q    <= in_BCLK;
      bclk_s2_q    <= bclk_s1_q;
      bclk_prev_q  <= bclk_s2_q;
      lrc_s1_q     <= in_RECLRC;
      lrc_s2_q     <= lrc_s1_q;
      dat_s1_q     <= in_RECDAT;
      dat_s2_q     <= dat_s1_q;
      state_q      <= state_d;
      channel_q    <= channel_d;
      lrc_prev_q   <= lrc_prev_d;
      left_ok_q    <= left_ok_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      pair_q       <= pair_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;

`ifdef I2S_RX_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (pair_q & out_valid_q & ~in_ready);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign out_overrun = overrun_q;
`else
  assign out_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: codec-side I2S driver, pair scoreboard, reset and overrun cases.
module tb_i2s_rx;

  localparam int BPS = 24;

`ifdef I2S_RX_OVERRUN_EN
  localparam logic [31:0] OVR_EXP = 32'd1;
`else
  localparam logic [31:0] OVR_EXP = 32'd0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           bclk = 1'b0;
  logic           lrc = 1'b0;
  logic           dat = 1'b0;
  logic           ready = 1'b1;
  logic [BPS-1:0] out_left, out_right;
  logic           out_valid, out_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lsb_mark = 0;
  logic last_bit = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_xfer = 1'b0;
  logic [2*BPS-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_rx #(.BPS(BPS)) dut (
    .in_clk     (clk),
    .in_rst     (rst),
    .in_BCLK    (bclk),
    .in_RECLRC  (lrc),
    .in_RECDAT  (dat),
    .in_ready   (ready),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .out_overrun(out_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks: data and LRC change with BCLK low, BCLK period = 4 clk
  task automatic send_bit(input logic l, input logic d, input logic mark);
    @(negedge clk);
    bclk = 1'b0;
    lrc = l;
    dat = d;
    last_bit = d;
    @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    if (mark) lsb_mark = cyc;
    @(negedge clk);
  endtask

  // slot position 0 repeats the previous bit (I2S delay), 1..BPS carry the word MSB first
  task automatic send_slot(input logic l, input logic [BPS-1:0] w, input int first,
                           input int last, input logic pad);
    for (int p = first; p <= last; p++) begin
      logic d;
      if (p == 0)        d = last_bit;
      else if (p <= BPS) d = w[BPS-p];
      else               d = pad;
      send_bit(l, d, l && (p == BPS));
    end
  endtask

  task automatic send_frame(input logic [BPS-1:0] l, input logic [BPS-1:0] r, input logic pad);
    send_slot(1'b0, l, 0, 31, pad);
    send_slot(1'b1, r, 0, 31, pad);
  endtask

  task automatic expect_pair(input logic [BPS-1:0] l, input logic [BPS-1:0] r);
    exp_q.push_back({l, r});
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [2*BPS-1:0] e;
    if (out_valid && !prev_valid) check("latency", 32'(cyc - lsb_mark), 32'd4);
    if (prev_xfer && ready) check("pulse_width", 32'(out_valid), 32'd0);
    if (out_valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("left", 32'(out_left), 32'(e[2*BPS-1:BPS]));
        check("right", 32'(out_right), 32'(e[BPS-1:0]));
      end
    end
    prev_xfer  = out_valid && ready;
    prev_valid = out_valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_left", 32'(out_left), 32'd0);
    check("rst_right", 32'(out_right), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(out_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_slot(1'b1, '0, 28, 31, 1'b0);

    // basic stream
    expect_pair(24'hA5A5A5, 24'h5A5A5A);
    expect_pair(24'hA5A5A5, 24'h5A5A5A);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0);

    // full scale, all ones/zeros, extra 32-bit slot bits set to 1
    expect_pair(24'h800000, 24'h7FFFFF);
    send_frame(24'h800000, 24'h7FFFFF, 1'b0);
    expect_pair(24'hFFFFFF, 24'hFFFFFF);
    send_frame(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    expect_pair(24'h000000, 24'h000000);
    send_frame(24'h000000, 24'h000000, 1'b1);
    expect_pair(24'h123456, 24'hABCDEF);
    send_frame(24'h123456, 24'hABCDEF, 1'b1);

    // backpressure across two frames
    set_ready(1'b0);
    expect_pair(24'h111111, 24'h222222);
    send_frame(24'h111111, 24'h222222, 1'b0);
    send_frame(24'h333333, 24'h444444, 1'b0);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_left", 32'(out_left), 32'h111111);
    check("held_right", 32'(out_right), 32'h222222);
    check("overrun", 32'(out_overrun), OVR_EXP);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("overrun_sticky", 32'(out_overrun), OVR_EXP);
    check("valid_after_xfer", 32'(out_valid), 32'd0);
    expect_pair(24'hC0FFEE, 24'h0BADF0);
    send_frame(24'hC0FFEE, 24'h0BADF0, 1'b0);

    // left slot cut after 10 bits: that frame yields nothing
    send_slot(1'b0, 24'h5555AA, 0, 10, 1'b0);
    send_slot(1'b1, 24'h777777, 0, 31, 1'b0);
    expect_pair(24'h4B1D00, 24'h00D1B4);
    send_frame(24'h4B1D00, 24'h00D1B4, 1'b0);

    // reset released mid-right slot, asserted again mid-left slot
    set_ready(1'b1);
    rst = 1'b1;
    #1 check("rst2_overrun", 32'(out_overrun), 32'd0);
    send_slot(1'b1, 24'h999999, 0, 9, 1'b0);
    rst = 1'b0;
    send_slot(1'b1, 24'h999999, 10, 31, 1'b0);
    expect_pair(24'hABCDEF, 24'hFEDCBA);
    send_frame(24'hABCDEF, 24'hFEDCBA, 1'b0);
    send_slot(1'b0, 24'h666666, 0, 14, 1'b0);
    check("pre_rst_left", 32'(out_left), 32'hABCDEF);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst3_left", 32'(out_left), 32'd0);
    check("rst3_right", 32'(out_right), 32'd0);
    check("rst3_valid", 32'(out_valid), 32'd0);
    send_slot(1'b0, 24'h666666, 15, 20, 1'b0);
    rst = 1'b0;
    send_slot(1'b0, 24'h666666, 21, 31, 1'b0);
    send_slot(1'b1, 24'h888888, 0, 31, 1'b0);
    expect_pair(24'h13579B, 24'h2468AC);
    send_frame(24'h13579B, 24'h2468AC, 1'b0);

    repeat (40) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver: recovers stereo PCM samples from an external codec's serial record stream (BCLK, LRC, data) and presents each left/right pair as a parallel word pair with a valid/ready handshake. It is the capture-side counterpart of the playback serializer. All codec pins are oversampled in the single system clock domain (12.288 MHz); BCLK is at most in_clk/4 (3.072 MHz, 64 BCLK per LRC frame).

## Interface
- BPS, 24, bits captured per channel word (MSB first); valid range 8..32.
- in_clk  input  1  system clock, 12.288 MHz; every register in the block uses it.
- in_rst  input  1  reset, asynchronous, active-high.
- in_BCLK  input  1  codec bit clock, asynchronous to in_clk, at most in_clk/4.
- in_RECLRC  input  1  codec record LR clock; 0 = left slot, 1 = right slot.
- in_RECDAT  input  1  codec record serial data.
- in_ready  input  1  downstream accepts the current pair.
- out_left  output  BPS  left sample of the presented pair.
- out_right  output  BPS  right sample of the presented pair.
- out_valid  output  1  pair present on out_left/out_right.
- out_overrun  output  1  sticky: a completed pair was dropped (see Configuration).

## Operation
- in_BCLK, in_RECLRC and in_RECDAT each pass through an identical 2-flop synchronizer. A BCLK rise is detected when synced BCLK = 1 and its registered previous value = 0. All actions below occur only on a detected rise.
- lrc_prev (reset 0) holds the LRC value sampled at the previous rise. A rise with synced LRC != lrc_prev is an LRC transition: channel <= synced LRC; state <= DELAY.
- States:
  - WAIT_SYNC (reset state): sampled bits ignored. An LRC transition moves the block to DELAY.
  - DELAY: this rise carries the I2S one-bit delay (the last bit of the previous slot) and is discarded. The next rise moves to SHIFT with bit_cnt = 0.
  - SHIFT: shift the sampled data in MSB first and increment bit_cnt. When bit_cnt reaches BPS, store the word in the channel's hold register and move to PAD.
  - PAD: remaining slot bits are ignored until the next LRC transition.
- Transitions take priority over state: an LRC transition in SHIFT before BPS bits have been captured (short slot) discards the partial word and clears left_ok.
- A completed left word sets left_ok. A completed right word with left_ok = 1 forms a pair and clears left_ok. A completed right word with left_ok = 0 is discarded.
- Pair handshake:
  - If out_valid = 0, or out_valid = 1 and in_ready = 1 on the same cycle, the pair loads into out_left/out_right and out_valid = 1.
  - Otherwise the new pair is dropped, the held pair is kept unchanged, and the overrun event fires.
- Transfer occurs on any cycle with out_valid & in_ready. Without a new pair on that cycle, out_valid drops on the next edge.
- out_left/out_right change only on a load. They hold their value while out_valid = 1 and !in_ready.

## Timing
- Reset values: out_left = 0, out_right = 0, out_valid = 0, out_overrun = 0. Also state = WAIT_SYNC, left_ok = 0, lrc_prev = 0, bit_cnt = 0.
- Assertion of in_rst clears all of the above immediately, including mid-slot or mid-handshake. A pending pair is lost.
- Latency: out_valid rises at the 3rd in_clk edge after the edge at which in_BCLK is first sampled high for the rise carrying bit BPS-1 of the right word.
- The first valid pair after reset is always a complete left slot followed by a complete right slot. A partial slot at the reset release never reaches the outputs.
- Throughput: one pair per LRC frame. The downstream must accept within one frame (64 BCLK = 256 in_clk) to avoid overrun.

## Configuration
- I2S_RX_OVERRUN_EN defined: out_overrun is set on any dropped pair and stays at 1 until in_rst.
- I2S_RX_OVERRUN_EN undefined: out_overrun is tied to 0 and the overrun logic is not built. Dropped pairs are still dropped and the held pair is still preserved.

## Test plan
- Reset then stream with BPS = 24, BCLK = in_clk/4, in_ready = 1, left = 24'hA5A5A5, right = 24'h5A5A5A -> a one-cycle out_valid pulse per frame, out_left = A5A5A5, out_right = 5A5A5A, at the specified latency.
- Full-scale values left = 24'h800000, right = 24'h7FFFFF, plus all-ones/all-zeros frames -> exact bit match; bits beyond 24 in a 32-bit slot are ignored.
- in_ready = 0 across 2 frames with I2S_RX_OVERRUN_EN defined -> first pair held stable, second dropped, out_overrun = 1. Raise in_ready -> one transfer with the first pair.
- Same as the previous scenario with the macro undefined -> out_overrun stays 0; data behaviour is identical.
- Left slot cut after 10 bits by an LRC toggle -> no pair for that frame; the next clean frame is output correctly.
- in_rst released mid-right slot, then asserted again mid-left slot of a later frame -> no pair from partial slots; outputs are 0 immediately on assertion; the next complete frame after release is output.
